// File: rtl/scale_demux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scale_demux : 1-to-2 registered demux with per-channel transfer counters
// Revision    : 1.0
// ----------------------------------------------------------------------------
module scale_demux #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 sel_a,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic                 out_a_valid,
  input  logic                 out_a_ready,
  output logic [WIDTH-1:0]     out_b,
  output logic                 out_b_valid,
  input  logic                 out_b_ready,
  output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b
);

  logic [WIDTH-1:0]     a_data_q, a_data_d;
  logic [WIDTH-1:0]     b_data_q, b_data_d;
  logic                 a_valid_q, a_valid_d;
  logic                 b_valid_q, b_valid_d;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic                 load_a, load_b;
  logic                 drain_a, drain_b;

  always_comb begin
    in_ready = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    // An unknown select falls into the default arm, so nothing is accepted.
    case (sel_a)
      1'b1: begin
        in_ready = !a_valid_q || out_a_ready;
        load_a   = in_valid && in_ready;
      end
      1'b0: begin
        in_ready = !b_valid_q || out_b_ready;
        load_b   = in_valid && in_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase

    drain_a = a_valid_q && out_a_ready;
    drain_b = b_valid_q && out_b_ready;

    a_data_d  = load_a ? in_data : a_data_q;
    b_data_d  = load_b ? in_data : b_data_q;
    // A load on the draining edge keeps the flag set for back-to-back words.
    a_valid_d = load_a ? 1'b1 : (drain_a ? 1'b0 : a_valid_q);
    b_valid_d = load_b ? 1'b1 : (drain_b ? 1'b0 : b_valid_q);
    cnt_a_d   = drain_a ? cnt_a_q + CNT_WIDTH'(1) : cnt_a_q;
    cnt_b_d   = drain_b ? cnt_b_q + CNT_WIDTH'(1) : cnt_b_q;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  assign out_a       = a_data_q;
  assign out_b       = b_data_q;
  assign out_a_valid = a_valid_q;
  assign out_b_valid = b_valid_q;
  assign cnt_a       = cnt_a_q;
  assign cnt_b       = cnt_b_q;

endmodule
`default_nettype wire

// File: tb/tb_scale_demux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_scale_demux : directed self-checking bench (8-bit and 2-bit counter builds)
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_scale_demux;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       sel_a = 1'b0;
  logic       out_a_ready = 1'b0;
  logic       out_b_ready = 1'b0;

  logic       in_ready, out_a_valid, out_b_valid;
  logic [7:0] out_a, out_b, cnt_a, cnt_b;
  logic       in_ready2, out_a_valid2, out_b_valid2;
  logic [7:0] out_a2, out_b2;
  logic [1:0] cnt_a2, cnt_b2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scale_demux #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid), .sel_a(sel_a),
    .in_ready(in_ready), .out_a(out_a), .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_b(out_b), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  scale_demux #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid), .sel_a(sel_a),
    .in_ready(in_ready2), .out_a(out_a2), .out_a_valid(out_a_valid2), .out_a_ready(out_a_ready),
    .out_b(out_b2), .out_b_valid(out_b_valid2), .out_b_ready(out_b_ready),
    .cnt_a(cnt_a2), .cnt_b(cnt_b2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    sel_a    = s;
    in_data  = d;
    #1;
  endtask

  task automatic check_chan_a(input string tag, input logic v, input logic [7:0] d);
    check({tag, "_a_valid"}, {31'd0, out_a_valid}, {31'd0, v});
    check({tag, "_a_data"}, {24'd0, out_a}, {24'd0, d});
  endtask

  task automatic check_chan_b(input string tag, input logic v, input logic [7:0] d);
    check({tag, "_b_valid"}, {31'd0, out_b_valid}, {31'd0, v});
    check({tag, "_b_data"}, {24'd0, out_b}, {24'd0, d});
  endtask

  task automatic check_cnts(input string tag, input logic [7:0] a, input logic [7:0] b);
    check({tag, "_cnt_a"}, {24'd0, cnt_a}, {24'd0, a});
    check({tag, "_cnt_b"}, {24'd0, cnt_b}, {24'd0, b});
    check({tag, "_cnt_a_w2"}, {30'd0, cnt_a2}, {30'd0, a[1:0]});
    check({tag, "_cnt_b_w2"}, {30'd0, cnt_b2}, {30'd0, b[1:0]});
  endtask

  // Upstream must keep data/select steady while a stalled offer is pending.
  logic       stall_q = 1'b0;
  logic [7:0] data_q  = 8'h00;
  logic       sel_q   = 1'b0;
  always @(posedge clk) begin
    if (rst_ && stall_q && in_valid) begin
      checks++;
      assert (in_data === data_q && sel_a === sel_q) else begin
        failures++;
        $error("FAIL hold_rule observed=%0h/%b expected=%0h/%b", in_data, sel_a, data_q, sel_q);
      end
    end
    stall_q = rst_ && in_valid && (in_ready !== 1'b1);
    data_q  = in_data;
    sel_q   = sel_a;
  end

  initial begin
    // Asynchronous reset between clock edges
    #3 rst_ = 1'b0;
    #1;
    check_chan_a("rst", 1'b0, 8'h00);
    check_chan_b("rst", 1'b0, 8'h00);
    check_cnts("rst", 8'd0, 8'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    rst_ = 1'b1;

    // Basic routing
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    drive(1'b1, 1'b1, 8'hA5);
    check("route_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_chan_a("route1", 1'b1, 8'hA5);
    check_chan_b("route1", 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h3C);
    tick();
    check_chan_b("route2", 1'b1, 8'h3C);
    check_chan_a("route2", 1'b0, 8'hA5);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check_chan_b("route3", 1'b0, 8'h3C);
    check_cnts("route", 8'd1, 8'd1);

    // Backpressure on A
    out_a_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h11);
    tick();
    check_chan_a("bp1", 1'b1, 8'h11);
    drive(1'b1, 1'b1, 8'h22);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    check_chan_a("bp2", 1'b1, 8'h11);
    check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    out_a_ready = 1'b1;
    #1;
    check("bp_in_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    check_chan_a("bp3", 1'b1, 8'h22);
    check_cnts("bp3", 8'd2, 8'd1);
    drive(1'b0, 1'b1, 8'h00);
    tick();
    check_chan_a("bp4", 1'b0, 8'h22);
    check_cnts("bp4", 8'd3, 8'd1);

    // Streaming 16 words from a fresh reset
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    out_a_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check_chan_a("stream", 1'b1, 8'(i));
    end
    drive(1'b0, 1'b1, 8'h00);
    tick();
    check_chan_a("stream_end", 1'b0, 8'h0F);
    check_cnts("stream", 8'd16, 8'd0);

    // Independence and counter wrap: B stalled while 5 words pass through A
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    out_b_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h5B);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'h60 + 8'(i));
      tick();
    end
    drive(1'b0, 1'b1, 8'h00);
    tick();
    check_chan_b("indep", 1'b1, 8'h5B);
    check_chan_a("indep", 1'b0, 8'h64);
    check_cnts("indep", 8'd5, 8'd0);

    // Unknown select with both channels full and stalled
    out_a_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h77);
    tick();
    check_chan_a("xsel_pre", 1'b1, 8'h77);
    drive(1'b1, 1'bx, 8'h99);
    check("xsel_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_chan_a("xsel", 1'b1, 8'h77);
    check_chan_b("xsel", 1'b1, 8'h5B);
    check_cnts("xsel", 8'd5, 8'd0);
    drive(1'b0, 1'b0, 8'h00);

    // Mid-operation asynchronous reset discards held words
    out_b_ready = 1'b1;
    #2 rst_ = 1'b0;
    #1;
    check_chan_b("midrst", 1'b0, 8'h00);
    check_chan_a("midrst", 1'b0, 8'h00);
    check_cnts("midrst", 8'd0, 8'd0);
    tick();
    check_cnts("midrst_hold", 8'd0, 8'd0);
    rst_ = 1'b1;

    // First transfer on the first edge after reset release
    out_a_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h42);
    tick();
    check_chan_a("first", 1'b1, 8'h42);
    drive(1'b0, 1'b1, 8'h00);
    out_a_ready = 1'b1;
    tick();
    check_cnts("first", 8'd1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
